// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; result lands in a one-entry tagged response register.
// Latency 1 cycle accept->rsp_valid_o; while the response is held (rsp_ready_i low) both readies drop and response outputs freeze.
module alu_share_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [3:0]      req0_aluctrl_i,
    input  logic [XLEN-1:0] req0_a_i,
    input  logic [XLEN-1:0] req0_b_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [3:0]      req1_aluctrl_i,
    input  logic [XLEN-1:0] req1_a_i,
    input  logic [XLEN-1:0] req1_b_i,
    output logic [3:0]      alu_ctrl_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    input  logic [XLEN-1:0] alu_result_i,
    output logic            rsp_valid_o,
    output logic            rsp_id_o,
    output logic [XLEN-1:0] rsp_result_o,
    input  logic            rsp_ready_i
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              grant0;
    logic              grant1;
    logic              can_issue;
    logic              accept;
    logic              rsp_id;
    logic [XLEN-1:0]   rsp_result;

    // On a tie the requester that did not win the last accept gets the grant.
    always_comb begin
        grant0 = req0_valid_i & (~req1_valid_i | last_grant);
        grant1 = req1_valid_i & (~req0_valid_i | ~last_grant);
    end

    assign can_issue    = (state == EMPTY) | rsp_ready_i;
    assign req0_ready_o = grant0 & can_issue;
    assign req1_ready_o = grant1 & can_issue;
    assign accept       = req0_ready_o | req1_ready_o;

    always_comb begin
        alu_ctrl_o = 4'b0000;
        alu_a_o    = '0;
        alu_b_o    = '0;
        if (grant0) begin
            alu_ctrl_o = req0_aluctrl_i;
            alu_a_o    = req0_a_i;
            alu_b_o    = req0_b_i;
        end else if (grant1) begin
            alu_ctrl_o = req1_aluctrl_i;
            alu_a_o    = req1_a_i;
            alu_b_o    = req1_b_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (rsp_ready_i && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_result <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            rsp_result <= alu_result_i;
            rsp_id     <= grant1;
            last_grant <= grant1;
        end
    end

    assign rsp_valid_o  = (state == FULL);
    assign rsp_id_o     = rsp_id;
    assign rsp_result_o = rsp_result;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: stimulus pushes hand-computed responses into a scoreboard, a negedge monitor pops on consumption.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1, rdy0, rdy1, rsp_rdy;
    logic [3:0]  c0, c1, alu_ctrl;
    logic [31:0] a0, b0, a1, b1, alu_a, alu_b, alu_res;
    logic        rsp_vld, rsp_id;
    logic [31:0] rsp_res;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    // Reference ALU: 0000 add, 1000 sub, anything else xor.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_res = alu_a + alu_b;
            4'b1000: alu_res = alu_a - alu_b;
            default: alu_res = alu_a ^ alu_b;
        endcase
    end

    alu_share_arbiter #(.XLEN(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_aluctrl_i(c0), .req0_a_i(a0), .req0_b_i(b0),
        .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_aluctrl_i(c1), .req1_a_i(a1), .req1_b_i(b1),
        .alu_ctrl_o(alu_ctrl), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_result_i(alu_res),
        .rsp_valid_o(rsp_vld), .rsp_id_o(rsp_id), .rsp_result_o(rsp_res), .rsp_ready_i(rsp_rdy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && rsp_vld && rsp_rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {31'd0, rsp_vld}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, e[32]});
                chk("rsp_result", rsp_res, e[31:0]);
            end
        end
    end

    task automatic drive(input logic iv0, input logic [3:0] ic0, input logic [31:0] ia0, ib0,
                         input logic iv1, input logic [3:0] ic1, input logic [31:0] ia1, ib1,
                         input logic irr);
        @(posedge clk);
        #1;
        v0 = iv0; c0 = ic0; a0 = ia0; b0 = ib0;
        v1 = iv1; c1 = ic1; a1 = ia1; b1 = ib1;
        rsp_rdy = irr;
    endtask

    task automatic expect_rdy(input string name, input logic e0, input logic e1);
        @(negedge clk);
        chk({name, "_rdy0"}, {31'd0, rdy0}, {31'd0, e0});
        chk({name, "_rdy1"}, {31'd0, rdy1}, {31'd0, e1});
    endtask

    initial begin
        rst_n = 1'b0; rsp_rdy = 1'b0;
        v0 = 0; c0 = 0; a0 = 0; b0 = 0;
        v1 = 0; c1 = 0; a1 = 0; b1 = 0;
        #3;
        chk("reset_valid", {31'd0, rsp_vld}, 32'd0);
        chk("reset_id", {31'd0, rsp_id}, 32'd0);
        chk("reset_result", rsp_res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: 5 + 7.
        drive(1, 4'b0000, 32'd5, 32'd7, 0, 4'b0000, 32'd0, 32'd0, 1);
        sb.push_back({1'b0, 32'd12});
        expect_rdy("single", 1, 0);

        // Requester 1 alone, pass-through of ctrl 1000 and operands.
        drive(0, 4'b0000, 32'd0, 32'd0, 1, 4'b1000, 32'hFFFF0000, 32'hDEAD0000, 1);
        sb.push_back({1'b1, 32'h21520000});
        expect_rdy("req1_only", 0, 1);
        chk("pt_ctrl8", {28'd0, alu_ctrl}, 32'h8);
        chk("pt_a", alu_a, 32'hFFFF0000);
        chk("pt_b", alu_b, 32'hDEAD0000);
        chk("stream_valid", {31'd0, rsp_vld}, 32'd1);

        // Both valid for four cycles: grants 0,1,0,1.
        drive(1, 4'b0000, 32'd1, 32'd2, 1, 4'b0000, 32'd10, 32'd20, 1);
        sb.push_back({1'b0, 32'd3});
        expect_rdy("rr0", 1, 0);
        drive(1, 4'b0000, 32'd100, 32'd200, 1, 4'b0000, 32'd10, 32'd20, 1);
        sb.push_back({1'b1, 32'd30});
        expect_rdy("rr1", 0, 1);
        drive(1, 4'b0000, 32'd100, 32'd200, 1, 4'b1111, 32'hF0F0F0F0, 32'h0F0F0F0F, 1);
        sb.push_back({1'b0, 32'd300});
        expect_rdy("rr2", 1, 0);
        drive(1, 4'b1000, 32'd50, 32'd8, 1, 4'b1111, 32'hF0F0F0F0, 32'h0F0F0F0F, 1);
        sb.push_back({1'b1, 32'hFFFFFFFF});
        expect_rdy("rr3", 0, 1);
        chk("pt_ctrlF", {28'd0, alu_ctrl}, 32'hF);

        // Backpressure: response held for three cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'b1000, 32'd50, 32'd8, 1, 4'b0000, 32'd7, 32'd7, 0);
            expect_rdy("bp", 0, 0);
            chk("bp_valid", {31'd0, rsp_vld}, 32'd1);
            chk("bp_id", {31'd0, rsp_id}, 32'd1);
            chk("bp_result", rsp_res, 32'hFFFFFFFF);
        end
        drive(1, 4'b1000, 32'd50, 32'd8, 1, 4'b0000, 32'd7, 32'd7, 1);
        sb.push_back({1'b0, 32'd42});
        expect_rdy("bp_release", 1, 0);
        drive(0, 4'b0000, 32'd0, 32'd0, 1, 4'b0000, 32'd7, 32'd7, 1);
        sb.push_back({1'b1, 32'd14});
        expect_rdy("after_release", 0, 1);
        chk("release_valid", {31'd0, rsp_vld}, 32'd1);

        // Idle five cycles after a req1 grant, then a tie goes to req0.
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'b0101, 32'd3, 32'd4, 0, 4'b0110, 32'd5, 32'd6, 1);
            expect_rdy("idle", 0, 0);
        end
        chk("idle_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("idle_a", alu_a, 32'd0);
        chk("idle_b", alu_b, 32'd0);
        chk("idle_valid", {31'd0, rsp_vld}, 32'd0);
        drive(1, 4'b0000, 32'd4, 32'd4, 1, 4'b0000, 32'd9, 32'd9, 1);
        sb.push_back({1'b0, 32'd8});
        expect_rdy("fair", 1, 0);
        drive(0, 4'b0000, 32'd0, 32'd0, 1, 4'b0000, 32'd9, 32'd9, 1);
        sb.push_back({1'b1, 32'd18});
        expect_rdy("fair_next", 0, 1);

        // Reset while FULL and stalled: the pending response is dropped.
        drive(0, 4'b0000, 32'd0, 32'd0, 0, 4'b0000, 32'd0, 32'd0, 0);
        @(negedge clk);
        chk("pre_reset_valid", {31'd0, rsp_vld}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", {31'd0, rsp_vld}, 32'd0);
        chk("async_reset_result", rsp_res, 32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 4'b0000, 32'd1, 32'd1, 1, 4'b0000, 32'd3, 32'd3, 1);
        sb.push_back({1'b0, 32'd2});
        expect_rdy("post_reset", 1, 0);
        drive(0, 4'b0000, 32'd0, 32'd0, 1, 4'b0000, 32'd3, 32'd3, 1);
        sb.push_back({1'b1, 32'd6});
        expect_rdy("post_reset_next", 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'b0000, 32'd0, 32'd0, 0, 4'b0000, 32'd0, 32'd0, 1);
        end
        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
